bidir_shift_register: RTL and testbench

Parameterised bidirectional shift register with synchronous parallel load, serial input and serial/parallel outputs. It is a general-purpose datapath primitive for serialisers, deserialisers and bit-stream alignment logic. All state lives in one WIDTH-bit register clocked on a single clock with an asynchronous active-low reset.

---
 rtl/bidir_shift_register.sv | 38 +++
 tb/tb_bidir_shift_register.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bidir_shift_register.sv
// Bidirectional WIDTH-bit shift register with parallel load, serial in and serial/parallel out.
// Latency: load and each shift land one cycle after the sampling edge; out is combinational from R and direction.
// Backpressure: none; en gates shifting, load overrides en, and rst=0 clears R at once.
module bidir_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             direction,
    input  logic             in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= parallel_in;
        end else if (en) begin
            if (direction) begin
                shreg <= {in, shreg[WIDTH-1:1]};
            end else begin
                shreg <= {shreg[WIDTH-2:0], in};
            end
        end
    end

    assign parallel_out = shreg;
    // out is the bit the next shift in the selected direction would drop
    assign out = direction ? shreg[0] : shreg[WIDTH-1];

endmodule

// File: tb/tb_bidir_shift_register.sv
// Randomised scoreboard bench for bidir_shift_register against an arithmetic reference model.
module tb_bidir_shift_register;

    localparam int W = 8;
    localparam logic [W-1:0] MASK = {W{1'b1}};

    logic         clk;
    logic         rst;
    logic         en;
    logic         direction;
    logic         in;
    logic [W-1:0] parallel_in;
    logic         load;
    logic [W-1:0] parallel_out;
    logic         out;

    bidir_shift_register #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .direction   (direction),
        .in          (in),
        .parallel_in (parallel_in),
        .load        (load),
        .parallel_out(parallel_out),
        .out         (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] po;
        logic         so;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] model_r;
    int           n_tests;
    int           n_fail;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, compared 1 time unit after it
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, ".parallel_out"}, parallel_out, e.po);
                check({e.name, ".out"}, {{(W-1){1'b0}}, out}, {{(W-1){1'b0}}, e.so});
            end
        end
    end

    // Drive one cycle's inputs at the falling edge, update the model at the rising edge
    task automatic step(input string name, input logic r, input logic ld, input logic [W-1:0] pi,
                        input logic e, input logic d, input logic i);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; parallel_in = pi; en = e; direction = d; in = i;
        if (!r) begin
            #1;
            check({name, ".async_clear"}, parallel_out, '0);
        end
        @(posedge clk);
        if (!r)
            model_r = '0;
        else if (ld)
            model_r = pi;
        else if (e && !d)
            model_r = ((model_r << 1) | W'(i)) & MASK;
        else if (e && d)
            model_r = (model_r >> 1) | (W'(i) << (W - 1));
        x.name = name;
        x.po   = model_r;
        x.so   = d ? ((model_r & W'(1)) != 0) : ((model_r >> (W - 1)) != 0);
        sb_q.push_back(x);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_r = '0;
        rst = 1'b0; en = 1'b0; direction = 1'b0; in = 1'b0; parallel_in = '0; load = 1'b0;

        #2;
        check("reset_po", parallel_out, '0);
        check("reset_out", {{(W-1){1'b0}}, out}, '0);
        repeat (3) step("rst_hold", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

        step("load_a5", 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);

        // Reset mid-cycle must clear without waiting for an edge
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_immediate", parallel_out, '0);
        for (int k = 0; k < 20; k++) step("rst_20", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

        for (int k = 0; k < 20; k++) step("shr_ones", 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        step("rst_pre_shl", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step("shl_ones", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);

        step("load_81", 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step("hold", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        step("load_prio", 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);

        step("sout_load", 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        step("sout_shl", 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        direction = 1'b1;
        #1;
        check("sout_dir_r", {{(W-1){1'b0}}, out}, W'(model_r[0]));
        direction = 1'b0;
        #1;
        check("sout_dir_l", {{(W-1){1'b0}}, out}, W'(model_r[W-1]));

        for (int k = 0; k < 400; k++) begin
            step("random",
                 ($urandom_range(0, 24) != 0),
                 ($urandom_range(0, 4) == 0),
                 W'($urandom),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        begin
            int budget;
            budget = 0;
            while (sb_q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (sb_q.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
